// File: rtl/rainbow_pkg.sv
// rtl/rainbow_pkg.sv - shared mode, segment types and constants for the rainbow PWM generator
package rainbow_pkg;

    typedef enum logic [1:0] {
        MODE_RAINBOW = 2'b00,
        MODE_BREATHE = 2'b01,
        MODE_HOLD    = 2'b10,
        MODE_OFF     = 2'b11
    } mode_e;

    typedef logic [2:0] seg_t;

    localparam int unsigned NUM_SEGS = 6;
    localparam seg_t        LAST_SEG = seg_t'(NUM_SEGS - 1);

endpackage

// File: rtl/rainbow_pwm_gen_channel.sv
// rtl/rainbow_pwm_gen_channel.sv - one PWM channel: period-aligned duty shadow, comparator, output flop
module pwm_channel
    import rainbow_pkg::*;
#(
    parameter int W          = 11,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] cnt_i,
    input  logic [W-1:0] duty_i,
    input  logic         load_i,
    input  logic         off_i,
    output logic         pin_o
);

    logic [W-1:0] shadow_q;
    logic [W-1:0] shadow_d;
    logic         pin_q;
    logic         pin_d;

    // Shadow only moves on the last count of a period so a period never mixes two duties.
    always_comb begin
        shadow_d = load_i ? duty_i : shadow_q;
        pin_d    = off_i ? ACTIVE_LOW : ((cnt_i < shadow_q) ^ ACTIVE_LOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            pin_q    <= ACTIVE_LOW;
        end else begin
            shadow_q <= shadow_d;
            pin_q    <= pin_d;
        end
    end

    assign pin_o = pin_q;

endmodule

// File: rtl/rainbow_pwm_gen.sv
// rtl/rainbow_pwm_gen.sv - RGB hue-cycling PWM generator; BREATHE mode built only with RAINBOW_BREATHE_EN
module rainbow_pwm_gen
    import rainbow_pkg::*;
#(
    parameter int PWM_INTERVAL = 1200,
    parameter int STEP_CYCLES  = 1667,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic [2:0] seg,
    output logic       cycle_done
);

    localparam int LW = $clog2(PWM_INTERVAL + 1);
    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [LW-1:0] M_V      = LW'(PWM_INTERVAL);
    localparam logic [LW-1:0] CNT_LAST = LW'(PWM_INTERVAL - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_CYCLES - 1);

    mode_e mode_s;
    logic  run;
    logic  off;
    logic  tick;
    logic  clear;

    logic [PW-1:0] pre_q, pre_d;
    logic [LW-1:0] lvl_q, lvl_d;
    seg_t          seg_q, seg_d;
    logic          done_q, done_d;
    logic [LW-1:0] cnt_q, cnt_d;

    seg_t          nxt_seg;
    logic          seg_wrap;
    logic [LW-1:0] inv;
    logic [LW-1:0] duty_r, duty_g, duty_b;
    logic          load;

    assign mode_s = mode_e'(mode);
    assign run    = (mode_s == MODE_RAINBOW) || (mode_s == MODE_BREATHE);
    assign off    = (mode_s == MODE_OFF);
    assign tick   = run && (pre_q == PRE_LAST);
    assign inv    = M_V - lvl_q;
    assign load   = (cnt_q == CNT_LAST);

`ifdef RAINBOW_BREATHE_EN
    logic breathe_q, breathe_d;

    // Remembers which running pattern owns the frozen state, so HOLD/OFF keep its duties.
    assign breathe_d = run ? (mode_s == MODE_BREATHE) : breathe_q;
    assign clear     = run && (breathe_d != breathe_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) breathe_q <= 1'b0;
        else     breathe_q <= breathe_d;
    end
`else
    assign clear = 1'b0;
`endif

    always_comb begin
        nxt_seg  = (seg_q == LAST_SEG) ? '0 : seg_q + 1'b1;
        seg_wrap = (seg_q == LAST_SEG);
`ifdef RAINBOW_BREATHE_EN
        if (breathe_q) begin
            nxt_seg  = (seg_q == '0) ? seg_t'(1) : '0;
            seg_wrap = (seg_q != '0);
        end
`endif
    end

    always_comb begin
        pre_d  = pre_q;
        lvl_d  = lvl_q;
        seg_d  = seg_q;
        done_d = 1'b0;
        cnt_d  = load ? '0 : cnt_q + 1'b1;
        if (clear) begin
            pre_d = '0;
            lvl_d = '0;
            seg_d = '0;
        end else if (run) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                if (lvl_q != M_V) begin
                    lvl_d = lvl_q + 1'b1;
                end else begin
                    lvl_d  = '0;
                    seg_d  = nxt_seg;
                    done_d = seg_wrap;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            lvl_q  <= '0;
            seg_q  <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pre_q  <= pre_d;
            lvl_q  <= lvl_d;
            seg_q  <= seg_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        duty_r = '0;
        duty_g = '0;
        duty_b = '0;
        case (seg_q)
            3'd0: begin duty_r = M_V;   duty_g = lvl_q; duty_b = '0;    end
            3'd1: begin duty_r = inv;   duty_g = M_V;   duty_b = '0;    end
            3'd2: begin duty_r = '0;    duty_g = M_V;   duty_b = lvl_q; end
            3'd3: begin duty_r = '0;    duty_g = inv;   duty_b = M_V;   end
            3'd4: begin duty_r = lvl_q; duty_g = '0;    duty_b = M_V;   end
            3'd5: begin duty_r = M_V;   duty_g = '0;    duty_b = inv;   end
            default: ;
        endcase
`ifdef RAINBOW_BREATHE_EN
        if (breathe_q) begin
            duty_r = (seg_q == '0) ? lvl_q : inv;
            duty_g = duty_r;
            duty_b = duty_r;
        end
`endif
    end

    pwm_channel #(.W(LW), .ACTIVE_LOW(ACTIVE_LOW != 0)) u_ch_r (
        .clk(clk), .rst(rst), .cnt_i(cnt_q), .duty_i(duty_r),
        .load_i(load), .off_i(off), .pin_o(RGB_R)
    );

    pwm_channel #(.W(LW), .ACTIVE_LOW(ACTIVE_LOW != 0)) u_ch_g (
        .clk(clk), .rst(rst), .cnt_i(cnt_q), .duty_i(duty_g),
        .load_i(load), .off_i(off), .pin_o(RGB_G)
    );

    pwm_channel #(.W(LW), .ACTIVE_LOW(ACTIVE_LOW != 0)) u_ch_b (
        .clk(clk), .rst(rst), .cnt_i(cnt_q), .duty_i(duty_b),
        .load_i(load), .off_i(off), .pin_o(RGB_B)
    );

    assign seg        = seg_q;
    assign cycle_done = done_q;

endmodule

// File: tb/tb_rainbow_pwm_gen.sv
// tb/tb_rainbow_pwm_gen.sv - randomized model-checked bench for rainbow_pwm_gen (honours RAINBOW_BREATHE_EN)
module tb_rainbow_pwm_gen;

    localparam int M    = 4;
    localparam int STEP = 2;
    localparam int AL   = 1;
`ifdef RAINBOW_BREATHE_EN
    localparam bit BREATHE_EN = 1'b1;
`else
    localparam bit BREATHE_EN = 1'b0;
`endif

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       rgb_r, rgb_g, rgb_b;
    logic [2:0] seg;
    logic       cycle_done;

    rainbow_pwm_gen #(
        .PWM_INTERVAL(M),
        .STEP_CYCLES (STEP),
        .ACTIVE_LOW  (AL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .RGB_R     (rgb_r),
        .RGB_G     (rgb_g),
        .RGB_B     (rgb_b),
        .seg       (seg),
        .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: n = clocks spent running since the last clear; seg/L follow from n by division.
    int n;
    int kind;
    int cyc;
    int shadow[3];
    int pin_e[3];
    int cd_e;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_lvl();
        return (n / STEP) % (M + 1);
    endfunction

    function automatic int m_seg();
        return ((n / STEP) / (M + 1)) % (kind != 0 ? 2 : 6);
    endfunction

    function automatic int m_duty(input int ch);
        int l, s;
        l = m_lvl();
        s = m_seg();
        if (kind != 0) return (s == 0) ? l : M - l;
        case (ch)
            0: case (s) 0: return M; 1: return M - l; 4: return l; 5: return M; default: return 0; endcase
            1: case (s) 0: return l; 1: return M; 2: return M; 3: return M - l; default: return 0; endcase
            default: case (s) 2: return l; 3: return M; 4: return M; 5: return M - l; default: return 0; endcase
        endcase
    endfunction

    task automatic model_reset();
        n    = 0;
        kind = 0;
        cyc  = 0;
        cd_e = 0;
        for (int i = 0; i < 3; i++) begin
            shadow[i] = 0;
            pin_e[i]  = AL;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_seg"}, int'(seg), m_seg());
        check_eq({tag, "_done"}, int'(cycle_done), cd_e);
        check_eq({tag, "_r"}, int'(rgb_r), pin_e[0]);
        check_eq({tag, "_g"}, int'(rgb_g), pin_e[1]);
        check_eq({tag, "_b"}, int'(rgb_b), pin_e[2]);
    endtask

    // Called at a falling edge: drive mode, let one rising edge pass, advance the model, compare.
    task automatic clk_step(input logic [1:0] m, input string tag);
        int em, cnt, last;
        int d[3];
        mode = m;
        @(posedge clk);
        em = int'(m);
        if (em == 1 && !BREATHE_EN) em = 0;
        cnt = cyc % M;
        for (int i = 0; i < 3; i++) d[i] = m_duty(i);
        for (int i = 0; i < 3; i++) pin_e[i] = (em == 3) ? AL : (((cnt < shadow[i]) ? 1 : 0) ^ AL);
        if (cnt == M - 1) for (int i = 0; i < 3; i++) shadow[i] = d[i];
        cd_e = 0;
        if (em <= 1) begin
            if (em != kind) begin
                kind = em;
                n    = 0;
            end else begin
                last = (kind != 0) ? 1 : 5;
                if ((n % STEP) == STEP - 1 && m_lvl() == M && m_seg() == last) cd_e = 1;
                n++;
            end
        end
        cyc++;
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Raises rst between edges and checks the outputs respond without any clock.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pulses, len;
        logic [1:0] rm;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            clk_step(2'b00, "rainbow");
            pulses += int'(cycle_done);
        end
        check_eq("rainbow_done_count", pulses, 1);

        async_reset("reset2");
        repeat (34) clk_step(2'b00, "to_seg3");
        check_eq("pre_off_seg", int'(seg), 3);
        repeat (20) clk_step(2'b11, "off");
        repeat (30) clk_step(2'b00, "resume");

        repeat (45) clk_step(2'b01, "breathe");
        repeat (20) clk_step(2'b00, "back_rainbow");
        repeat (10) clk_step(2'b10, "hold");

        async_reset("reset3");
        repeat (45) clk_step(2'b00, "to_seg4");
        check_eq("pre_rst_seg", int'(seg), 4);
        async_reset("mid_seg4_rst");
        repeat (20) clk_step(2'b00, "restart");

        for (int k = 0; k < 200; k++) begin
            rm  = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 14);
            for (int j = 0; j < len; j++) clk_step(rm, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
